// File: rtl/rmst_pkg.sv
// Shared constants, state type and length helper for the read-master port model.
package rmst_pkg;

  localparam int WORD_BITS      = 128;
  localparam int BYTES_PER_WORD = WORD_BITS / 8;
  localparam int WORD_SHIFT     = $clog2(BYTES_PER_WORD);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  // Byte length to word count, rounding a partial last word up to a full word.
  function automatic logic [63:0] bytes_to_words(input logic [63:0] len_bytes);
    logic [63:0] whole;
    logic        partial;
    whole   = len_bytes >> WORD_SHIFT;
    partial = |(len_bytes & 64'(BYTES_PER_WORD - 1));
    return whole + {63'd0, partial};
  endfunction

endpackage

// File: rtl/sc_fifo_sa.sv
// Synchronous show-ahead FIFO: the head word is visible on dout_o whenever
// the FIFO is non-empty; a pop exposes the next word on the following cycle.
module sc_fifo_sa #(
  parameter int W     = 128,
  parameter int DEPTH = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push_i,
  input  logic [W-1:0]           din_i,
  input  logic                   pop_i,
  output logic [W-1:0]           dout_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   empty_o,
  output logic                   full_o
);

  localparam int PW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW:0]   count_q, count_d;
  logic          push_ok, pop_ok;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == (PW+1)'(DEPTH));
  assign count_o = count_q;
  // Pops on an empty FIFO and pushes on a full one are dropped silently.
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;
  // Force zero when empty so the output is defined straight out of reset.
  assign dout_o  = empty_o ? '0 : mem[rd_ptr_q];

  // Pointer and occupancy next-state; push and pop together leave count unchanged.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + PW'(1);
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + (PW+1)'(1);
      2'b01:   count_d = count_q - (PW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer/count registers, flushed by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array write.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_q] <= din_i;
  end

endmodule

// File: rtl/rmst_port_model.sv
// Responder side of one read-master port: takes go/base/length commands,
// reads words from an internal RAM and streams them through a show-ahead FIFO.
module rmst_port_model
  import rmst_pkg::*;
#(
  parameter int DW         = 128,
  parameter int AW         = 32,
  parameter int MEM_WORDS  = 1024,
  parameter int FIFO_DEPTH = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         ctrl_fixed_location,
  input  logic [AW-1:0]                ctrl_read_base,
  input  logic [AW-1:0]                ctrl_read_length,
  input  logic                         ctrl_go,
  output logic                         ctrl_done,
  input  logic                         user_read_buffer,
  output logic [DW-1:0]                user_buffer_data,
  output logic                         user_data_available,
  input  logic                         mem_wr_en,
  input  logic [$clog2(MEM_WORDS)-1:0] mem_wr_addr,
  input  logic [DW-1:0]                mem_wr_data
);

  localparam int MAW = $clog2(MEM_WORDS);
  localparam int CW  = $clog2(FIFO_DEPTH) + 1;

  state_e          state_q, state_d;
  logic [MAW-1:0]  word_addr_q, word_addr_d;
  logic [AW-1:0]   words_left_q, words_left_d;
  logic            fixed_q, fixed_d;
  logic            inflight_q;
  logic [DW-1:0]   mem [MEM_WORDS];
  logic [DW-1:0]   rd_data_q;
  logic [CW-1:0]   fifo_count;
  logic            fifo_empty, fifo_full;
  logic [CW:0]     occupancy;
  logic            issue;
  logic [AW-1:0]   go_words;
  logic [MAW-1:0]  go_addr;
  logic [AW-1:0]   base_word;
  logic            unused_base_bits;

  // Byte address to word address; the byte offset within a word is dropped.
  assign base_word        = ctrl_read_base >> WORD_SHIFT;
  assign go_addr          = base_word[MAW-1:0];
  assign go_words         = AW'(bytes_to_words(64'(ctrl_read_length)));
  assign unused_base_bits = ^ctrl_read_base[WORD_SHIFT-1:0];

  // Words already queued plus the one coming out of the RAM; issuing only
  // below capacity means every fetched word is guaranteed a FIFO slot.
  assign occupancy = {1'b0, fifo_count} + {{CW{1'b0}}, inflight_q};
  assign issue     = (state_q == ST_FETCH) && !fifo_full &&
                     (occupancy < (CW+1)'(FIFO_DEPTH));

  assign ctrl_done           = (state_q == ST_IDLE);
  assign user_data_available = !fifo_empty;

  // Transfer sequencing: latch the command in IDLE, issue reads in FETCH,
  // wait out the last RAM read in DRAIN. Commands outside IDLE are ignored.
  always_comb begin
    state_d      = state_q;
    word_addr_d  = word_addr_q;
    words_left_d = words_left_q;
    fixed_d      = fixed_q;
    case (state_q)
      ST_IDLE: begin
        if (ctrl_go) begin
          word_addr_d  = go_addr;
          words_left_d = go_words;
          fixed_d      = ctrl_fixed_location;
          if (go_words != '0) state_d = ST_FETCH;
        end
      end
      ST_FETCH: begin
        if (issue) begin
          words_left_d = words_left_q - AW'(1);
          if (!fixed_q) word_addr_d = word_addr_q + MAW'(1);
          if (words_left_q == AW'(1)) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (inflight_q) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Control registers; reset abandons any transfer in progress.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      word_addr_q  <= '0;
      words_left_q <= '0;
      fixed_q      <= 1'b0;
      inflight_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      word_addr_q  <= word_addr_d;
      words_left_q <= words_left_d;
      fixed_q      <= fixed_d;
      inflight_q   <= issue;
    end
  end

  // Word RAM: backdoor write plus registered read; a same-address read in
  // the write cycle sees the old contents.
  always_ff @(posedge clk) begin
    if (mem_wr_en) mem[mem_wr_addr] <= mem_wr_data;
    if (issue)     rd_data_q <= mem[word_addr_q];
  end

  sc_fifo_sa #(
    .W     (DW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (inflight_q),
    .din_i   (rd_data_q),
    .pop_i   (user_read_buffer),
    .dout_o  (user_buffer_data),
    .count_o (fifo_count),
    .empty_o (fifo_empty),
    .full_o  (fifo_full)
  );

endmodule

// File: tb/tb_rmst_port_model.sv
// Directed plus randomized bench for rmst_port_model with a word-queue
// reference model of the expected read stream.
module tb_rmst_port_model;

  localparam int DW         = 128;
  localparam int AW         = 32;
  localparam int MEM_WORDS  = 1024;
  localparam int FIFO_DEPTH = 32;
  localparam int BPW        = DW / 8;
  localparam int MAW        = $clog2(MEM_WORDS);

  logic           clk = 1'b0;
  logic           rst;
  logic           ctrl_fixed_location;
  logic [AW-1:0]  ctrl_read_base;
  logic [AW-1:0]  ctrl_read_length;
  logic           ctrl_go;
  logic           ctrl_done;
  logic           user_read_buffer;
  logic [DW-1:0]  user_buffer_data;
  logic           user_data_available;
  logic           mem_wr_en;
  logic [MAW-1:0] mem_wr_addr;
  logic [DW-1:0]  mem_wr_data;

  logic [DW-1:0]  model_mem [MEM_WORDS];
  logic [DW-1:0]  exp_q [$];
  int             n_checks = 0;
  int             n_fail   = 0;

  always #5 clk = ~clk;

  rmst_port_model #(
    .DW(DW), .AW(AW), .MEM_WORDS(MEM_WORDS), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk                 (clk),
    .rst                 (rst),
    .ctrl_fixed_location (ctrl_fixed_location),
    .ctrl_read_base      (ctrl_read_base),
    .ctrl_read_length    (ctrl_read_length),
    .ctrl_go             (ctrl_go),
    .ctrl_done           (ctrl_done),
    .user_read_buffer    (user_read_buffer),
    .user_buffer_data    (user_buffer_data),
    .user_data_available (user_data_available),
    .mem_wr_en           (mem_wr_en),
    .mem_wr_addr         (mem_wr_addr),
    .mem_wr_data         (mem_wr_data)
  );

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DW-1:0] rand_word();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic mem_write(input int addr, input logic [DW-1:0] d);
    logic [31:0] a;
    a           = addr;
    mem_wr_en   = 1'b1;
    mem_wr_addr = a[MAW-1:0];
    mem_wr_data = d;
    tick();
    mem_wr_en   = 1'b0;
    model_mem[addr] = d;
    $display("write  addr=%0d data=%h", addr, d);
  endtask

  // Issue a command from IDLE and queue the words the model says it returns.
  task automatic go(input bit fixed, input logic [AW-1:0] base, input logic [AW-1:0] len,
                    output int n_words);
    int start;
    int a;
    n_words = int'((longint'(len) + BPW - 1) / BPW);
    start   = int'((base >> 4) & 32'(MEM_WORDS - 1));
    for (int i = 0; i < n_words; i++) begin
      a = fixed ? start : (start + i) % MEM_WORDS;
      exp_q.push_back(model_mem[a]);
    end
    ctrl_fixed_location = fixed;
    ctrl_read_base      = base;
    ctrl_read_length    = len;
    ctrl_go             = 1'b1;
    tick();
    ctrl_go             = 1'b0;
    $display("go     fixed=%0d base=%h len=%0d words=%0d", fixed, base, len, n_words);
  endtask

  // Pop with the given probability, checking each word against the model,
  // until the model queue is empty and the port reports done.
  task automatic consume(input int pop_pct, input int budget, output int low_cycles);
    int cyc;
    cyc        = 0;
    low_cycles = 0;
    forever begin
      if (!ctrl_done) low_cycles++;
      user_read_buffer = 1'b0;
      if (user_data_available && exp_q.size() > 0 && $urandom_range(99) < pop_pct) begin
        check("pop_data", user_buffer_data, exp_q[0]);
        $display("pop    data=%h", user_buffer_data);
        void'(exp_q.pop_front());
        user_read_buffer = 1'b1;
      end
      if (exp_q.size() == 0 && ctrl_done) break;
      if (cyc >= budget) begin
        check("consume_timeout_left", DW'(exp_q.size()), DW'(0));
        check("consume_timeout_done", DW'(ctrl_done), DW'(1));
        exp_q.delete();
        break;
      end
      tick();
      cyc++;
    end
    tick();
    user_read_buffer = 1'b0;
    check("no_extra_word", DW'(user_data_available), DW'(0));
  endtask

  initial begin
    int n, low, pct;
    logic [AW-1:0] rbase, rlen;
    bit rfixed;

    rst = 1'b1;
    ctrl_fixed_location = 1'b0;
    ctrl_read_base = '0;
    ctrl_read_length = '0;
    ctrl_go = 1'b0;
    user_read_buffer = 1'b0;
    mem_wr_en = 1'b0;
    mem_wr_addr = '0;
    mem_wr_data = '0;
    repeat (3) tick();
    check("reset_done", DW'(ctrl_done), DW'(1));
    check("reset_avail", DW'(user_data_available), DW'(0));
    check("reset_data", user_buffer_data, DW'(0));
    rst = 1'b0;
    tick();

    // Random background contents for the whole RAM.
    for (int i = 0; i < MEM_WORDS; i++) begin
      mem_wr_en   = 1'b1;
      mem_wr_addr = MAW'(i);
      mem_wr_data = rand_word();
      model_mem[i] = mem_wr_data;
      tick();
    end
    mem_wr_en = 1'b0;

    // Sequential 16-word read with an always-ready consumer.
    for (int i = 0; i < 16; i++) mem_write(i, DW'(i));
    go(1'b0, 32'h0, 32'd256, n);
    consume(100, 500, low);
    check("seq16_done_low_cycles", DW'(low), DW'(n + 1));

    // Fixed-location read repeats one word.
    mem_write(7, {16{8'hA5}});
    go(1'b1, 32'h70, 32'd64, n);
    consume(100, 200, low);
    check("fixed_done_low_cycles", DW'(low), DW'(5));

    // Consumer stalls: FIFO fills, transfer holds, then drains in order.
    go(1'b0, 32'h100, 32'd1024, n);
    repeat (80) tick();
    check("stall_avail", DW'(user_data_available), DW'(1));
    check("stall_done", DW'(ctrl_done), DW'(0));
    consume(100, 2000, low);

    // Zero length never starts; 17 bytes round up to two words.
    go(1'b0, 32'h40, 32'd0, n);
    for (int i = 0; i < 4; i++) begin
      check("len0_done", DW'(ctrl_done), DW'(1));
      check("len0_avail", DW'(user_data_available), DW'(0));
      tick();
    end
    go(1'b0, 32'h200, 32'd17, n);
    consume(100, 200, low);
    check("len17_done_low_cycles", DW'(low), DW'(3));

    // Address wraps past the top of the RAM.
    go(1'b0, 32'((MEM_WORDS - 2) * 16), 32'd64, n);
    consume(100, 200, low);
    check("wrap_done_low_cycles", DW'(low), DW'(5));

    // A second go mid-transfer is ignored.
    go(1'b0, 32'h400, 32'd160, n);
    repeat (3) tick();
    ctrl_read_base   = 32'h0;
    ctrl_read_length = 32'd1000;
    ctrl_go          = 1'b1;
    tick();
    ctrl_go          = 1'b0;
    consume(50, 1000, low);

    // Reset mid-FETCH aborts everything, then a fresh go works.
    go(1'b0, 32'h0, 32'd1024, n);
    repeat (10) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_q.delete();
    check("midrst_avail", DW'(user_data_available), DW'(0));
    check("midrst_done", DW'(ctrl_done), DW'(1));
    check("midrst_data", user_buffer_data, DW'(0));
    for (int i = 0; i < 3; i++) begin
      tick();
      check("postrst_avail", DW'(user_data_available), DW'(0));
    end
    go(1'b0, 32'h3000, 32'd48, n);
    consume(100, 200, low);
    check("postrst_done_low_cycles", DW'(low), DW'(4));

    // Randomized commands, contents and consumer rates.
    for (int t = 0; t < 30; t++) begin
      for (int w = 0; w < 3; w++) mem_write(int'($urandom_range(MEM_WORDS - 1)), rand_word());
      rfixed = ($urandom_range(3) == 0);
      rbase  = $urandom;
      rlen   = $urandom_range(800);
      pct    = (t % 3 == 0) ? 100 : int'($urandom_range(20, 100));
      go(rfixed, rbase, rlen, n);
      consume(pct, 20000, low);
      if (pct == 100) check("rand_done_low_cycles", DW'(low), DW'(n == 0 ? 0 : n + 1));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
